// File: rtl/score_keeper.sv
// Round scorer: start score per level, 1 Hz countdown, one-shot +/- bonus tiles, win/loss freeze.
// Optional SCORE_HISCORE_EN adds a best-winning-score register; all outputs are registered.
module score_keeper #(
   parameter int SCORE_W    = 8,
   parameter int START_EASY = 60,
   parameter int START_MED  = 90,
   parameter int START_HARD = 120,
   parameter int BONUS      = 5
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               playHard,
   input  logic               playMedium,
   input  logic               playEasy,
   input  logic               externalReset,
   input  logic [4:0]         scorePlusFiveX,
   input  logic [4:0]         scorePlusFiveY,
   input  logic [4:0]         scoreMinusFiveX,
   input  logic [4:0]         scoreMinusFiveY,
   input  logic               start,
   input  logic [4:0]         player_x,
   input  logic [4:0]         player_y,
   input  logic               move_valid,
   input  logic               goal_reached,
   input  logic               tick_1hz,
   output logic [SCORE_W-1:0] score,
   output logic               plus_used,
   output logic               minus_used,
   output logic               playing,
   output logic               won,
   output logic               lost
`ifdef SCORE_HISCORE_EN
   ,
   output logic [SCORE_W-1:0] hiscore
`endif
);

   // One-hot encoding lets the state flags come straight off the state register.
   typedef enum logic [2:0] {
      IDLE    = 3'b000,
      PLAYING = 3'b001,
      WON     = 3'b010,
      LOST    = 3'b100
   } state_t;

   localparam int SW = SCORE_W + 2;
   localparam logic signed [SW-1:0] BONUS_S = SW'(BONUS);
   localparam logic signed [SW-1:0] ONE_S   = SW'(1);
   localparam logic signed [SW-1:0] MAX_S   = $signed({2'b00, {SCORE_W{1'b1}}});

   state_t             state_q, state_d;
   logic [SCORE_W-1:0] score_q, score_d;
   logic               plus_used_q, plus_used_d;
   logic               minus_used_q, minus_used_d;
   logic [4:0]         plus_x_q, plus_y_q, minus_x_q, minus_y_q;
   logic [4:0]         plus_x_d, plus_y_d, minus_x_d, minus_y_d;

   logic               level_ok;
   logic [SCORE_W-1:0] start_score;
   logic               plus_hit, minus_hit;
   logic signed [SW-1:0] sum;
   logic [SCORE_W-1:0] clamped;

   assign level_ok = $onehot({playHard, playMedium, playEasy});

   always_comb begin
      start_score = SCORE_W'(START_EASY);
      if (playHard)
         start_score = SCORE_W'(START_HARD);
      else if (playMedium)
         start_score = SCORE_W'(START_MED);
   end

   assign plus_hit  = move_valid && !plus_used_q &&
                      (player_x == plus_x_q) && (player_y == plus_y_q);
   assign minus_hit = move_valid && !minus_used_q &&
                      (player_x == minus_x_q) && (player_y == minus_y_q);

   // Net delta summed first so coincident events saturate once, not per event.
   always_comb begin
      sum = $signed({2'b00, score_q});
      if (tick_1hz)
         sum = sum - ONE_S;
      if (plus_hit)
         sum = sum + BONUS_S;
      if (minus_hit)
         sum = sum - BONUS_S;
      if (sum < 0)
         clamped = '0;
      else if (sum > MAX_S)
         clamped = {SCORE_W{1'b1}};
      else
         clamped = sum[SCORE_W-1:0];
   end

   always_comb begin
      state_d      = state_q;
      score_d      = score_q;
      plus_used_d  = plus_used_q;
      minus_used_d = minus_used_q;
      plus_x_d     = plus_x_q;
      plus_y_d     = plus_y_q;
      minus_x_d    = minus_x_q;
      minus_y_d    = minus_y_q;
      if (externalReset) begin
         state_d      = IDLE;
         score_d      = '0;
         plus_used_d  = 1'b0;
         minus_used_d = 1'b0;
      end else begin
         case (state_q)
            PLAYING: begin
               score_d      = clamped;
               plus_used_d  = plus_used_q | plus_hit;
               minus_used_d = minus_used_q | minus_hit;
               if (goal_reached)
                  state_d = WON;
               else if (clamped == '0)
                  state_d = LOST;
            end
            default: begin
               if (start && level_ok) begin
                  state_d      = PLAYING;
                  score_d      = start_score;
                  plus_used_d  = 1'b0;
                  minus_used_d = 1'b0;
                  plus_x_d     = scorePlusFiveX;
                  plus_y_d     = scorePlusFiveY;
                  minus_x_d    = scoreMinusFiveX;
                  minus_y_d    = scoreMinusFiveY;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         score_q      <= '0;
         plus_used_q  <= 1'b0;
         minus_used_q <= 1'b0;
         plus_x_q     <= '0;
         plus_y_q     <= '0;
         minus_x_q    <= '0;
         minus_y_q    <= '0;
      end else begin
         state_q      <= state_d;
         score_q      <= score_d;
         plus_used_q  <= plus_used_d;
         minus_used_q <= minus_used_d;
         plus_x_q     <= plus_x_d;
         plus_y_q     <= plus_y_d;
         minus_x_q    <= minus_x_d;
         minus_y_q    <= minus_y_d;
      end
   end

   assign score      = score_q;
   assign plus_used  = plus_used_q;
   assign minus_used = minus_used_q;
   assign {lost, won, playing} = state_q;

`ifdef SCORE_HISCORE_EN
   // Compare one cycle after the win, once the final score sits in score_q.
   logic               win_pend_q;
   logic [SCORE_W-1:0] hiscore_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         win_pend_q <= 1'b0;
         hiscore_q  <= '0;
      end else begin
         win_pend_q <= (state_q == PLAYING) && (state_d == WON);
         if (win_pend_q && (score_q > hiscore_q))
            hiscore_q <= score_q;
      end
   end

   assign hiscore = hiscore_q;
`endif

endmodule

// File: tb/tb_score_keeper.sv
// Directed-vector bench for score_keeper; hiscore checks build only with SCORE_HISCORE_EN.
module tb_score_keeper;

   logic       clock = 1'b0;
   logic       reset;
   logic       playHard, playMedium, playEasy, externalReset;
   logic [4:0] scorePlusFiveX, scorePlusFiveY, scoreMinusFiveX, scoreMinusFiveY;
   logic       start;
   logic [4:0] player_x, player_y;
   logic       move_valid, goal_reached, tick_1hz;
   logic [7:0] score;
   logic       plus_used, minus_used, playing, won, lost;
`ifdef SCORE_HISCORE_EN
   logic [7:0] hiscore;
`endif

   int n_cmp = 0;
   int n_err = 0;

   score_keeper dut (
      .clock           (clock),
      .reset           (reset),
      .playHard        (playHard),
      .playMedium      (playMedium),
      .playEasy        (playEasy),
      .externalReset   (externalReset),
      .scorePlusFiveX  (scorePlusFiveX),
      .scorePlusFiveY  (scorePlusFiveY),
      .scoreMinusFiveX (scoreMinusFiveX),
      .scoreMinusFiveY (scoreMinusFiveY),
      .start           (start),
      .player_x        (player_x),
      .player_y        (player_y),
      .move_valid      (move_valid),
      .goal_reached    (goal_reached),
      .tick_1hz        (tick_1hz),
      .score           (score),
      .plus_used       (plus_used),
      .minus_used      (minus_used),
      .playing         (playing),
      .won             (won),
      .lost            (lost)
`ifdef SCORE_HISCORE_EN
      ,
      .hiscore         (hiscore)
`endif
   );

   always #5 clock = ~clock;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One clock edge, then sample 1 time unit later and drop the single-cycle pulses.
   task automatic cyc();
      @(posedge clock);
      #1;
      start        = 1'b0;
      move_valid   = 1'b0;
      goal_reached = 1'b0;
      tick_1hz     = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         tick_1hz = 1'b1;
         cyc();
      end
   endtask

   task automatic move_to(input logic [4:0] x, input logic [4:0] y);
      player_x   = x;
      player_y   = y;
      move_valid = 1'b1;
   endtask

   task automatic set_tiles(input logic [4:0] px, input logic [4:0] py,
                            input logic [4:0] mx, input logic [4:0] my);
      scorePlusFiveX  = px;
      scorePlusFiveY  = py;
      scoreMinusFiveX = mx;
      scoreMinusFiveY = my;
   endtask

   // flags packed as {playing, won, lost}
   function automatic logic [2:0] flags();
      return {playing, won, lost};
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; externalReset = 1'b0;
      playHard = 1'b0; playMedium = 1'b0; playEasy = 1'b0;
      start = 1'b0; move_valid = 1'b0; goal_reached = 1'b0; tick_1hz = 1'b0;
      player_x = '0; player_y = '0;
      set_tiles(5'd1, 5'd21, 5'd10, 5'd6);
      cyc(); cyc();
      reset = 1'b0;
      cyc();
      check_val("rst_score", score, 0);
      check_val("rst_flags", flags(), 3'b000);
      check_val("rst_used", {plus_used, minus_used}, 2'b00);

      // Easy round, countdown, win freezes the score
      playEasy = 1'b1; start = 1'b1; cyc();
      check_val("easy_start", score, 60);
      check_val("easy_flags", flags(), 3'b100);
      for (int i = 1; i <= 3; i++) begin
         tick_1hz = 1'b1; cyc();
         check_val("easy_tick", score, 32'(60 - i));
      end
      goal_reached = 1'b1; cyc();
      check_val("win_flags", flags(), 3'b010);
      check_val("win_score", score, 57);
      tick_1hz = 1'b1; move_to(5'd1, 5'd21); cyc();
      check_val("frozen_score", score, 57);
      check_val("frozen_plus", plus_used, 0);

      // Hard round restarted from WON; tiles latched at start
      playEasy = 1'b0; playHard = 1'b1; start = 1'b1; cyc();
      check_val("hard_start", score, 120);
      set_tiles(5'd3, 5'd3, 5'd3, 5'd4);
      playHard = 1'b0; playMedium = 1'b1;
      move_to(5'd1, 5'd21); cyc();
      check_val("plus_once", score, 125);
      check_val("plus_used", plus_used, 1);
      move_to(5'd1, 5'd21); cyc();
      check_val("plus_twice", score, 125);
      move_to(5'd3, 5'd3); cyc();
      check_val("unlatched_tile", score, 125);
      goal_reached = 1'b1; cyc();
      check_val("hard_won", flags(), 3'b010);

      // Medium round to 3, minus tile drives it to 0 -> loss
      set_tiles(5'd1, 5'd21, 5'd10, 5'd6);
      start = 1'b1; cyc();
      check_val("med_start", score, 90);
      ticks(87);
      check_val("med_at3", score, 3);
      check_val("med_flags", flags(), 3'b100);
      move_to(5'd10, 5'd6); cyc();
      check_val("lost_score", score, 0);
      check_val("lost_flags", flags(), 3'b001);
      check_val("minus_used", minus_used, 1);

      // Easy round from LOST: tick + plus tile, then tick + goal at 1
      playMedium = 1'b0; playEasy = 1'b1; start = 1'b1; cyc();
      check_val("restart_used", {plus_used, minus_used}, 2'b00);
      ticks(50);
      check_val("easy_at10", score, 10);
      tick_1hz = 1'b1; move_to(5'd1, 5'd21); cyc();
      check_val("tick_plus", score, 14);
      ticks(13);
      check_val("easy_at1", score, 1);
      tick_1hz = 1'b1; goal_reached = 1'b1; cyc();
      check_val("goal_zero_flags", flags(), 3'b010);
      check_val("goal_zero_score", score, 0);

      // Plus and minus on the same cell: both consumed, net is just the tick
      set_tiles(5'd4, 5'd4, 5'd4, 5'd4);
      start = 1'b1; cyc();
      tick_1hz = 1'b1; move_to(5'd4, 5'd4); cyc();
      check_val("same_cell_score", score, 59);
      check_val("same_cell_used", {plus_used, minus_used}, 2'b11);

      // externalReset aborts round; invalid levels ignored
      externalReset = 1'b1; cyc();
      check_val("ext_score", score, 0);
      check_val("ext_flags", flags(), 3'b000);
      check_val("ext_used", {plus_used, minus_used}, 2'b00);
      start = 1'b1; cyc();
      check_val("ext_beats_start", flags(), 3'b000);
      externalReset = 1'b0; playEasy = 1'b0;
      start = 1'b1; cyc();
      check_val("nolevel_flags", flags(), 3'b000);
      playEasy = 1'b1; playHard = 1'b1; start = 1'b1; cyc();
      check_val("twolevel_flags", flags(), 3'b000);
      check_val("twolevel_score", score, 0);
      playHard = 1'b0;

`ifdef SCORE_HISCORE_EN
      reset = 1'b1; cyc(); reset = 1'b0;
      check_val("hi_rst", hiscore, 0);
      start = 1'b1; cyc();
      ticks(3);
      goal_reached = 1'b1; cyc();
      check_val("hi_win_cycle", hiscore, 0);
      cyc();
      check_val("hi_57", hiscore, 57);
      start = 1'b1; cyc();
      ticks(20);
      goal_reached = 1'b1; cyc();
      check_val("hi_second_score", score, 40);
      cyc();
      check_val("hi_keep57", hiscore, 57);
      externalReset = 1'b1; cyc(); externalReset = 1'b0;
      check_val("hi_ext_keep", hiscore, 57);
      reset = 1'b1; cyc(); reset = 1'b0;
      check_val("hi_reset", hiscore, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
